// File: rtl/exe_muldiv_seq.sv
// Iterative radix-2 multiply/divide sequencer for MULT/MULTU/DIV/DIVU beside the EX-stage ALU.
// One step per clock on operand magnitudes, then one fix-up cycle that signs the result and writes HI/LO.
module exe_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic               zero_div_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // op[0] selects the signed variants; the core only ever sees magnitudes.
    assign a_neg = op[0] & src_a[WIDTH-1];
    assign b_neg = op[0] & src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    always_comb begin
        // NOTE: each always_comb target is given a default before any branch, so no latch is inferred.
        acc_d   = acc_q;
        rem_d   = rem_q;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
        shifted = {rem_q, acc_q[WIDTH-1]};
        // Partial remainder is below the divisor, so bit WIDTH of the difference is the borrow.
        trial   = shifted - {1'b0, opb_q};
        if (!is_div_q) begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (trial[WIDTH]) begin
            rem_d              = shifted[WIDTH-1:0];
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d              = trial[WIDTH-1:0];
            acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
        end
    end

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign quo_fix  = zero_div_q ? {WIDTH{1'b1}}
                                 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_hi_q ? -rem_q : rem_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            zero_div_q <= 1'b0;
            opb_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        state_q    <= CALC;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        is_div_q   <= op[1];
                        neg_lo_q   <= a_neg ^ b_neg;
                        neg_hi_q   <= a_neg;
                        zero_div_q <= op[1] & (src_b == '0);
                        opb_q      <= b_mag;
                        acc_q      <= {{WIDTH{1'b0}}, a_mag};
                        rem_q      <= '0;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    // A flush on this edge discards the result and suppresses done.
                    if (!flush) begin
                        done_q <= 1'b1;
                        dbz_q  <= zero_div_q;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign stall       = busy_q | (start & (state_q == IDLE));
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Bench for exe_muldiv_seq: latency-level reference model checked every cycle,
// plus directed operations with hand-computed HI/LO values.
module tb_exe_muldiv_seq;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic          flush;
    logic          busy, stall, done, div_by_zero;
    logic [W-1:0]  hi_out, lo_out;

    int vectors = 0;
    int errors  = 0;

    exe_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result {div_by_zero, HI, LO} from plain arithmetic.
    function automatic logic [64:0] model(input logic [1:0] f_op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint     sa, sb, p;
        logic [63:0] u;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f_op)
            2'b00: begin
                u = {32'd0, a} * {32'd0, b};
                return {1'b0, u};
            end
            2'b01: begin
                p = sa * sb;
                return {1'b0, p};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (f_op == 2'b10) begin
                    q = a / b;
                    r = a % b;
                end else begin
                    p = sa / sb;
                    q = p[31:0];
                    p = sa % sb;
                    r = p[31:0];
                end
                return {1'b0, r, q};
            end
        endcase
    endfunction

    // Reference: an accepted start completes WIDTH+1 edges later unless flushed.
    logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    int           m_left = 0;
    logic [64:0]  p_res = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_hi   <= '0;   m_lo   <= '0;   m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_dbz, m_hi, m_lo} <= p_res;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !flush) begin
                p_res  <= model(op, src_a, src_b);
                m_busy <= 1'b1;
                m_left <= W + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy",  busy,   m_busy);
        check("stall", stall,  m_busy | (start & ~m_busy));
        check("done",  done,   m_done);
        check("hi",    hi_out, m_hi);
        check("lo",    lo_out, m_lo);
        if (m_done) check("dbz", div_by_zero, m_dbz);
    end

    task automatic run(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb,
                       input logic lit, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_dbz, input string name);
        int n;
        op = f_op; src_a = fa; src_b = fb; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!done && n < 40);
        check({name, "_latency"}, n, 33);
        if (lit) begin
            check({name, "_hi"},  hi_out,      e_hi);
            check({name, "_lo"},  lo_out,      e_lo);
            check({name, "_dbz"}, div_by_zero, e_dbz);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi",   hi_out, 0);
        check("rst_lo",   lo_out, 0);
        check("rst_dbz",  div_by_zero, 0);
        reset = 1'b1;
        @(posedge clk); #2;

        // Consecutive calls start on the cycle done is high (back-to-back).
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0, "multu_max");
        run(2'b01, -32'sd3,       32'd7,         1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, "mult_neg");
        run(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0000_0000, 0, "mult_min");
        run(2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'h8000_0001, 0, "mult_max_m1");
        run(2'b00, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0001, 32'h0000_0000, 0, "multu_carry");
        run(2'b11, -32'sd7,       32'd2,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div_neg_pos");
        run(2'b11, -32'sd7,       -32'sd2,       1, 32'hFFFF_FFFF, 32'h0000_0003, 0, "div_neg_neg");
        run(2'b11, 32'd7,         -32'sd2,       1, 32'h0000_0001, 32'hFFFF_FFFD, 0, "div_pos_neg");
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 0, "div_ovf");
        run(2'b10, 32'd100,       32'd0,         1, 32'd100,       32'hFFFF_FFFF, 1, "divu_zero");
        run(2'b11, -32'sd5,       32'd0,         1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, "div_zero");
        run(2'b10, 32'd100,       32'd7,         1, 32'd2,         32'd14,        0, "divu_100_7");

        // Flush in CALC with an ignored mid-op start; HI/LO keep 2/14.
        op = 2'b01; src_a = -32'sd3; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        op = 2'b10; src_a = 32'd9; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_hi", hi_out, 32'd2);
        check("flush_lo", lo_out, 32'd14);
        n = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (done) n++;
        end
        check("flush_nodone", n, 0);

        // Flush on the completing edge wins.
        op = 2'b00; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (32) @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        check("fixflush_done", done, 0);
        check("fixflush_busy", busy, 0);
        check("fixflush_lo", lo_out, 32'd14);

        // Flush together with start in IDLE drops the start.
        op = 2'b00; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; flush = 1'b0;
        check("idleflush_busy", busy, 0);

        // Reset at CALC cycle 5, then a full-latency op.
        op = 2'b00; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy",  busy, 0);
        check("midrst_stall", stall, 0);
        check("midrst_hi",    hi_out, 0);
        check("midrst_lo",    lo_out, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        run(2'b00, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0, "after_rst");

        // Model-checked operations on random operands, with an occasional zero divisor.
        for (int i = 0; i < 8; i++) begin
            run(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'd0 : $urandom,
                0, '0, '0, 1'b0, "rand");
        end
        repeat (3) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
